// File: rtl/np_iomem_router.sv
// iomem router: decodes each CPU access by address page, forwards it to one slave port,
// and completes unmapped or unanswered accesses with an error word so the CPU never stalls.
module np_iomem_router #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter logic [7:0]  BASE_PAGE  = 8'h03,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       m_valid,
  output logic                       m_ready,
  input  logic [3:0]                 m_wstrb,
  input  logic [31:0]                m_addr,
  input  logic [31:0]                m_wdata,
  output logic [31:0]                m_rdata,
  output logic [NUM_SLAVES-1:0]      s_valid,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  output logic [3:0]                 s_wstrb,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  input  logic [32*NUM_SLAVES-1:0]   s_rdata,
  output logic [7:0]                 err_count,
  output logic [31:0]                err_addr,
  output logic [1:0]                 dbg_state_o
);

  localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  // Handshake: the CPU holds m_valid and the request fields until m_ready pulses for one
  // cycle; each slave sees s_valid held with stable s_* buses until it returns s_ready.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0]   s_valid_q, s_valid_d;
  logic                    m_ready_q, m_ready_d;
  logic [31:0]             m_rdata_q, m_rdata_d;
  logic [3:0]              s_wstrb_q, s_wstrb_d;
  logic [31:0]             s_addr_q, s_addr_d;
  logic [31:0]             s_wdata_q, s_wdata_d;
  logic [7:0]              err_count_q, err_count_d;
  logic [31:0]             err_addr_q, err_addr_d;

  logic [7:0]              page;
  logic                    hit;
  logic                    sel_ready;
  logic [31:0]             sel_rdata;
  logic [7:0]              err_count_inc;

  // Pages below BASE_PAGE wrap to large values and fall out as misses.
  assign page          = m_addr[31:24] - BASE_PAGE;
  assign hit           = (page < 8'(NUM_SLAVES));
  assign err_count_inc = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    s_valid_d   = s_valid_q;
    m_ready_d   = 1'b0;
    m_rdata_d   = m_rdata_q;
    s_wstrb_d   = s_wstrb_q;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    case (state_q)
      IDLE: begin
        if (m_valid && !m_ready_q) begin
          s_addr_d  = m_addr;
          s_wdata_d = m_wdata;
          s_wstrb_d = m_wstrb;
          if (hit) begin
            sel_d     = page[SEL_W-1:0];
            s_valid_d = NUM_SLAVES'(1) << page[SEL_W-1:0];
            cnt_d     = 8'd0;
            state_d   = ACCESS;
          end else begin
            m_rdata_d   = ERR_DATA;
            err_addr_d  = m_addr;
            err_count_d = err_count_inc;
            state_d     = RESPOND;
          end
        end
      end
      ACCESS: begin
        // A ready arriving in the final timeout cycle still counts as a normal completion.
        if (sel_ready) begin
          m_rdata_d = sel_rdata;
          s_valid_d = '0;
          state_d   = RESPOND;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          s_valid_d   = '0;
          m_rdata_d   = ERR_DATA;
          err_addr_d  = s_addr_q;
          err_count_d = err_count_inc;
          state_d     = RESPOND;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESPOND: begin
        m_ready_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      cnt_q       <= 8'd0;
      s_valid_q   <= '0;
      m_ready_q   <= 1'b0;
      m_rdata_q   <= 32'd0;
      s_wstrb_q   <= 4'd0;
      s_addr_q    <= 32'd0;
      s_wdata_q   <= 32'd0;
      err_count_q <= 8'd0;
      err_addr_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      s_valid_q   <= s_valid_d;
      m_ready_q   <= m_ready_d;
      m_rdata_q   <= m_rdata_d;
      s_wstrb_q   <= s_wstrb_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign m_ready     = m_ready_q;
  assign m_rdata     = m_rdata_q;
  assign s_valid     = s_valid_q;
  assign s_wstrb     = s_wstrb_q;
  assign s_addr      = s_addr_q;
  assign s_wdata     = s_wdata_q;
  assign err_count   = err_count_q;
  assign err_addr    = err_addr_q;
  assign dbg_state_o = state_q;

endmodule
